// File: rtl/priv_1_12_ext_csr_initiator_pkg.sv
// Shared types for the priv_ext_if CSR initiator: op encoding, FSM states, RO address marker.
package priv_ext_csr_pkg;

  typedef enum logic [1:0] {
    OP_ILL = 2'b00,
    OP_RW  = 2'b01,
    OP_RS  = 2'b10,
    OP_RC  = 2'b11
  } csr_op_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_READ  = 2'b01,
    ST_WRITE = 2'b10,
    ST_RESP  = 2'b11
  } csr_init_state_t;

  // addr[11:10] == 2'b11 marks a read-only CSR
  localparam logic [1:0] RO_ADDR_TOP = 2'b11;

endpackage

// File: rtl/priv_1_12_ext_csr_initiator_if.sv
// Pipeline request/response and extension-responder signals of the CSR initiator.
interface priv_1_12_ext_csr_initiator_if;

  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [11:0] req_addr;
  logic [31:0] req_wdata;
  logic [1:0]  req_priv;
  logic        flush;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [11:0] ext_csr_addr;
  logic        ext_csr_active;
  logic [31:0] ext_value_in;
  logic [31:0] ext_value_out;
  logic        ext_ack;
  logic        ext_invalid_csr;

  modport master (
    input  req_valid, req_op, req_addr, req_wdata, req_priv, flush, rsp_ready,
           ext_value_out, ext_ack, ext_invalid_csr,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
           ext_csr_addr, ext_csr_active, ext_value_in
  );

  modport slave (
    output req_valid, req_op, req_addr, req_wdata, req_priv, flush, rsp_ready,
           ext_value_out, ext_ack, ext_invalid_csr,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
           ext_csr_addr, ext_csr_active, ext_value_in
  );

endinterface

// File: rtl/priv_1_12_csr_alu.sv
// Read-modify-write datapath for CSRRW/RS/RC: new value and whether a write is needed.
module priv_1_12_csr_alu
  import priv_ext_csr_pkg::*;
(
  input  csr_op_t     op,
  input  logic [31:0] old_val,
  input  logic [31:0] wdata,
  output logic [31:0] new_val,
  output logic        do_write
);

  always_comb begin
    new_val = old_val;
    case (op)
      OP_RW:   new_val = wdata;
      OP_RS:   new_val = old_val | wdata;
      OP_RC:   new_val = old_val & ~wdata;
      default: new_val = old_val;
    endcase
    // RS/RC with a zero operand are pure reads and must not strobe the responder
    do_write = (op == OP_RW) || (wdata != 32'd0);
  end

endmodule

// File: rtl/priv_1_12_ext_csr_initiator.sv
// CSR initiator: read phase, optional single-cycle write strobe, then held response.
module priv_1_12_ext_csr_initiator
  import priv_ext_csr_pkg::*;
#(
  parameter int ACK_TIMEOUT = 16
) (
  input  logic                          CLK,
  input  logic                          nRST,
  priv_1_12_ext_csr_initiator_if.master bus
);

  localparam int CW = $clog2(ACK_TIMEOUT) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(ACK_TIMEOUT - 1);

  csr_init_state_t state_q, state_d;
  csr_op_t         op_q, op_d;
  logic [11:0]     addr_q, addr_d;
  logic [31:0]     wdata_q, wdata_d;
  logic [31:0]     new_q, new_d;
  logic [31:0]     rdata_q, rdata_d;
  logic            err_q, err_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic [31:0] alu_new;
  logic        alu_wr;
  logic        pre_err;
  logic        ro_fault;
  logic        timed_out;

  priv_1_12_csr_alu u_alu (
    .op       (op_q),
    .old_val  (bus.ext_value_out),
    .wdata    (wdata_q),
    .new_val  (alu_new),
    .do_write (alu_wr)
  );

  assign pre_err   = (bus.req_op == 2'b00) || (bus.req_addr[9:8] > bus.req_priv);
  assign ro_fault  = alu_wr && (addr_q[11:10] == RO_ADDR_TOP);
  assign timed_out = (cnt_q == CNT_LAST);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= ST_IDLE;
      op_q    <= OP_ILL;
      addr_q  <= '0;
      wdata_q <= '0;
      new_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      new_q   <= new_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (bus.req_valid) state_d = pre_err ? ST_RESP : ST_READ;
      ST_READ: begin
        if (bus.flush)                                     state_d = ST_IDLE;
        else if (bus.ext_ack && !bus.ext_invalid_csr && alu_wr && !ro_fault)
                                                           state_d = ST_WRITE;
        else if (bus.ext_ack || timed_out)                 state_d = ST_RESP;
      end
      ST_WRITE: state_d = ST_RESP;
      ST_RESP:  if (bus.rsp_ready) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    op_d    = op_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    new_d   = new_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: if (bus.req_valid) begin
        op_d    = csr_op_t'(bus.req_op);
        addr_d  = bus.req_addr;
        wdata_d = bus.req_wdata;
        cnt_d   = '0;
        rdata_d = '0;
        err_d   = pre_err;
      end
      ST_READ: if (!bus.flush) begin
        if (!timed_out) cnt_d = cnt_q + 1'b1;
        if (bus.ext_ack && !bus.ext_invalid_csr) begin
          new_d   = alu_new;
          err_d   = ro_fault;
          rdata_d = ro_fault ? 32'd0 : bus.ext_value_out;
        end else if (bus.ext_ack || timed_out) begin
          err_d   = 1'b1;
          rdata_d = '0;
        end
      end
      ST_RESP: if (bus.rsp_ready) begin
        rdata_d = '0;
        err_d   = 1'b0;
      end
      default: ;
    endcase
  end

  always_comb begin
    bus.req_ready      = (state_q == ST_IDLE);
    bus.rsp_valid      = (state_q == ST_RESP);
    bus.rsp_rdata      = rdata_q;
    bus.rsp_err        = err_q;
    bus.ext_csr_addr   = addr_q;
    bus.ext_csr_active = (state_q == ST_WRITE);
    bus.ext_value_in   = (state_q == ST_WRITE) ? new_q : 32'd0;
  end

endmodule

// File: tb/tb_priv_1_12_ext_csr_initiator.sv
// Scoreboarded bench for the CSR initiator with a simple programmable responder.
module tb_priv_1_12_ext_csr_initiator;

  logic CLK = 1'b0;
  logic nRST = 1'b0;
  always #5 CLK = ~CLK;

  priv_1_12_ext_csr_initiator_if bus();

  priv_1_12_ext_csr_initiator #(.ACK_TIMEOUT(4)) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (bus.master)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          wr;
    logic [31:0] wval;
  } exp_t;

  exp_t sb[$];
  int   n_run = 0, n_fail = 0;
  int   cyc = 0, acc_cyc = 0, wr_base = 0, wr_tot = 0;
  logic [31:0] wr_val = '0;
  logic [11:0] wr_addr = '0;

  always @(posedge CLK) cyc <= cyc + 1;

  always @(negedge CLK)
    if (nRST && bus.ext_csr_active) begin
      wr_tot  = wr_tot + 1;
      wr_val  = bus.ext_value_in;
      wr_addr = bus.ext_csr_addr;
    end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic exp_t mk(logic [31:0] rd, logic er, int lat, int wr, logic [31:0] wv);
    exp_t e;
    e.rdata = rd; e.err = er; e.lat = lat; e.wr = wr; e.wval = wv;
    return e;
  endfunction

  task automatic send(input logic [1:0] op, input logic [11:0] addr, input logic [31:0] wd,
                      input logic [1:0] priv, input exp_t e, input bit push);
    @(negedge CLK);
    chk("req_ready", 32'(bus.req_ready), 32'd1);
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_addr  = addr;
    bus.req_wdata = wd;
    bus.req_priv  = priv;
    acc_cyc = cyc;
    wr_base = wr_tot;
    if (push) sb.push_back(e);
    @(negedge CLK);
    bus.req_valid = 1'b0;
  endtask

  task automatic get_rsp(input int hold);
    int t = 0;
    exp_t e;
    logic [31:0] r0;
    logic e0;
    while (!bus.rsp_valid && t < 40) begin
      @(negedge CLK);
      t++;
    end
    if (!bus.rsp_valid) begin
      chk("rsp_timeout", 32'd0, 32'd1);
      return;
    end
    if (sb.size() == 0) begin
      chk("sb_underflow", 32'd0, 32'd1);
      return;
    end
    e = sb.pop_front();
    chk("latency", 32'(cyc - acc_cyc), 32'(e.lat));
    chk("rdata", bus.rsp_rdata, e.rdata);
    chk("err", 32'(bus.rsp_err), 32'(e.err));
    chk("wr_count", 32'(wr_tot - wr_base), 32'(e.wr));
    if (e.wr > 0) chk("wr_value", wr_val, e.wval);
    r0 = bus.rsp_rdata;
    e0 = bus.rsp_err;
    repeat (hold) begin
      @(negedge CLK);
      chk("hold_valid", 32'(bus.rsp_valid), 32'd1);
      chk("hold_rdata", bus.rsp_rdata, r0);
      chk("hold_err", 32'(bus.rsp_err), 32'(e0));
    end
    bus.rsp_ready = 1'b1;
    @(negedge CLK);
    bus.rsp_ready = 1'b0;
    chk("rsp_drop", 32'(bus.rsp_valid), 32'd0);
  endtask

  initial begin
    bus.req_valid = 1'b0; bus.req_op = 2'b00; bus.req_addr = '0; bus.req_wdata = '0;
    bus.req_priv = 2'd3; bus.flush = 1'b0; bus.rsp_ready = 1'b0;
    bus.ext_ack = 1'b1; bus.ext_invalid_csr = 1'b0; bus.ext_value_out = '0;

    repeat (2) @(negedge CLK);
    chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_rdata", bus.rsp_rdata, 32'd0);
    chk("rst_err", 32'(bus.rsp_err), 32'd0);
    chk("rst_active", 32'(bus.ext_csr_active), 32'd0);
    chk("rst_addr", 32'(bus.ext_csr_addr), 32'd0);
    chk("rst_value_in", bus.ext_value_in, 32'd0);
    nRST = 1'b1;

    // RW with immediate ack: one strobe, 3-cycle latency
    bus.ext_value_out = 32'h1234;
    send(2'b01, 12'h3B0, 32'h8000_0000, 2'd3, mk(32'h1234, 1'b0, 3, 1, 32'h8000_0000), 1'b1);
    get_rsp(0);
    chk("wr_addr", 32'(wr_addr), 32'h3B0);

    bus.ext_value_out = 32'h0F;
    send(2'b10, 12'h3A0, 32'h0, 2'd3, mk(32'h0F, 1'b0, 2, 0, 32'h0), 1'b1);
    get_rsp(0);
    send(2'b11, 12'h3A0, 32'h3, 2'd3, mk(32'h0F, 1'b0, 3, 1, 32'h0C), 1'b1);
    get_rsp(0);

    // read-only CSR: write faults, pure read succeeds
    bus.ext_value_out = 32'hABCD;
    send(2'b01, 12'hF11, 32'h5, 2'd3, mk(32'h0, 1'b1, 2, 0, 32'h0), 1'b1);
    get_rsp(0);
    bus.ext_value_out = 32'h77;
    send(2'b10, 12'hF11, 32'h0, 2'd3, mk(32'h77, 1'b0, 2, 0, 32'h0), 1'b1);
    get_rsp(0);

    // privilege fault and bad op never enter READ
    send(2'b10, 12'h3A0, 32'h1, 2'd0, mk(32'h0, 1'b1, 1, 0, 32'h0), 1'b1);
    get_rsp(0);
    send(2'b00, 12'h3B0, 32'h1, 2'd3, mk(32'h0, 1'b1, 1, 0, 32'h0), 1'b1);
    get_rsp(0);

    // no ack: error 4 cycles after READ entry
    bus.ext_ack = 1'b0;
    send(2'b01, 12'h3B0, 32'h1, 2'd3, mk(32'h0, 1'b1, 5, 0, 32'h0), 1'b1);
    get_rsp(0);
    bus.ext_ack = 1'b1;

    bus.ext_invalid_csr = 1'b1;
    send(2'b01, 12'h3B0, 32'h1, 2'd3, mk(32'h0, 1'b1, 2, 0, 32'h0), 1'b1);
    get_rsp(0);
    bus.ext_invalid_csr = 1'b0;

    // back-pressured response must hold stable
    bus.ext_value_out = 32'h0F;
    send(2'b10, 12'h300, 32'hF0, 2'd3, mk(32'h0F, 1'b0, 3, 1, 32'hFF), 1'b1);
    get_rsp(5);

    // flush in READ cycle 2
    bus.ext_ack = 1'b0;
    send(2'b01, 12'h3B0, 32'h55, 2'd3, mk(32'h0, 1'b0, 0, 0, 32'h0), 1'b0);
    @(negedge CLK);
    bus.flush = 1'b1;
    @(negedge CLK);
    bus.flush = 1'b0;
    bus.ext_ack = 1'b1;
    chk("flush_idle", 32'(bus.req_ready), 32'd1);
    repeat (6) begin
      chk("flush_no_rsp", 32'(bus.rsp_valid), 32'd0);
      @(negedge CLK);
    end
    chk("flush_no_wr", 32'(wr_tot - wr_base), 32'd0);

    bus.ext_value_out = 32'h1234;
    send(2'b01, 12'h3B0, 32'h55, 2'd3, mk(32'h1234, 1'b0, 3, 1, 32'h55), 1'b1);
    get_rsp(0);

    // reset pulse during WRITE
    bus.ext_value_out = 32'h9;
    send(2'b01, 12'h3B0, 32'hAA, 2'd3, mk(32'h0, 1'b0, 0, 0, 32'h0), 1'b0);
    @(negedge CLK);
    chk("mid_write_active", 32'(bus.ext_csr_active), 32'd1);
    chk("mid_write_value", bus.ext_value_in, 32'hAA);
    nRST = 1'b0;
    #1;
    chk("rstw_active", 32'(bus.ext_csr_active), 32'd0);
    chk("rstw_value_in", bus.ext_value_in, 32'd0);
    chk("rstw_addr", 32'(bus.ext_csr_addr), 32'd0);
    chk("rstw_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rstw_req_ready", 32'(bus.req_ready), 32'd1);
    @(negedge CLK);
    nRST = 1'b1;

    bus.ext_value_out = 32'h0F0F;
    send(2'b11, 12'h3A0, 32'h000F, 2'd3, mk(32'h0F0F, 1'b0, 3, 1, 32'h0F00), 1'b1);
    get_rsp(0);

    chk("sb_left", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
